// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// single-ported scratch memory. One transaction is in flight at a time; the
// granted requester gets a one-cycle done pulse and, for reads, held read data.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_avail,
  input  logic [NUM_REQ-1:0]          req_r_en,
  input  logic [NUM_REQ-1:0]          req_w_en,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_ptr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_store,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ*DATA_W-1:0]   req_data_load,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        err_both
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_grant, cur_id, pick_id;
  logic               pick_vld;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               lat_wr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] eligible;

  // A requester that is available but has no operation enabled is ignored.
  assign eligible = req_avail & (req_r_en | req_w_en);

  // Round-robin pick: first eligible id scanning upward from last_grant+1.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!pick_vld && eligible[ID_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_wr ? DONE : WAIT_RD;
      WAIT_RD: if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the winner's request in IDLE, count read latency.
  // A request with both enables set is executed as a write and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
      cnt        <= '0;
      err_both   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          cur_id     <= pick_id;
          last_grant <= pick_id;
          lat_addr   <= req_ptr[pick_id*ADDR_W +: ADDR_W];
          lat_wdata  <= req_data_store[pick_id*DATA_W +: DATA_W];
          lat_wr     <= req_w_en[pick_id];
          if (req_w_en[pick_id] && req_r_en[pick_id]) err_both <= 1'b1;
        end
        ISSUE:   cnt <= CNT_W'(MEM_LAT - 1);
        WAIT_RD: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Per-requester read data, updated only when that requester's read lands.
  always_ff @(posedge clk) begin
    if (rst)
      req_data_load <= '0;
    else if (state == WAIT_RD && cnt == '0)
      req_data_load[cur_id*DATA_W +: DATA_W] <= mem_rdata;
  end

  // Outputs decoded from state; strobes exist only in ISSUE.
  always_comb begin
    req_done  = '0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_we    = (state == ISSUE) &&  lat_wr;
    mem_re    = (state == ISSUE) && !lat_wr;
    busy      = (state != IDLE);
    grant_id  = cur_id;
    if (state == DONE) req_done[cur_id] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// hand-written sequences for contention, reset abort, both-enables and
// avail-without-enable cases. A small latency-accurate memory model sits on
// the memory port.
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 32, DW = 32, LAT = 2;

  logic            clk = 1'b0, rst;
  logic [N-1:0]    req_avail, req_r_en, req_w_en, req_done;
  logic [N*AW-1:0] req_ptr;
  logic [N*DW-1:0] req_data_store, req_data_load;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_we, mem_re, busy, err_both;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_avail(req_avail), .req_r_en(req_r_en),
    .req_w_en(req_w_en), .req_ptr(req_ptr), .req_data_store(req_data_store),
    .req_done(req_done), .req_data_load(req_data_load), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id), .err_both(err_both)
  );

  // Memory model: 256 words, read data appears LAT cycles after mem_re.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
    end else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= mem_re ? mem[mem_addr[7:0]] : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic av, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    req_avail[id] = av; req_r_en[id] = rd; req_w_en[id] = wr;
    req_ptr[id*AW +: AW] = a; req_data_store[id*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  // Drive one request, wait (bounded) for its done pulse, then drop it.
  // lat: cycles from request visible in IDLE to done; scyc: cycle of strobe.
  task automatic run_op(input int id, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int nre, output int nwe,
                        output int scyc, output int bad);
    logic [N-1:0] mine;
    mine = '0; mine[id] = 1'b1;
    set_req(id, 1'b1, rd, wr, a, d);
    lat = -1; nre = 0; nwe = 0; scyc = -1; bad = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (mem_re) begin nre++; scyc = n; if (mem_addr !== a) bad++; end
      if (mem_we) begin nwe++; scyc = n; if (mem_addr !== a || mem_wdata !== d) bad++; end
      if ((req_done & ~mine) != '0) bad++;
      if (req_done[id]) begin lat = n; break; end
    end
    set_req(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  typedef struct {
    int          id;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          exp_lat;
    logic [31:0] exp_load;
  } vec_t;

  vec_t tbl [7];
  int lat, nre, nwe, scyc, bad, k, did;
  logic [31:0] exp_ld [N];

  initial begin
    rst = 1'b1; req_avail = '0; req_r_en = '0; req_w_en = '0;
    req_ptr = '0; req_data_store = '0;
    tbl[0] = '{0, 1'b1, 1'b0, 32'h10, 32'h0,        4, 32'hDEADBEEF};
    tbl[1] = '{2, 1'b0, 1'b1, 32'h20, 32'h3F800000, 2, 32'h0};
    tbl[2] = '{3, 1'b1, 1'b0, 32'h20, 32'h0,        4, 32'h3F800000};
    tbl[3] = '{1, 1'b0, 1'b1, 32'h30, 32'h12345678, 2, 32'h0};
    tbl[4] = '{1, 1'b1, 1'b0, 32'h30, 32'h0,        4, 32'h12345678};
    tbl[5] = '{0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 2, 32'hDEADBEEF};
    tbl[6] = '{2, 1'b1, 1'b0, 32'h05, 32'h0,        4, 32'hA0000005};

    step(); step(); rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err_both, 0);
    chk("rst_load", req_data_load[63:0] | req_data_load[127:64], 0);
    chk("rst_addr", mem_addr, 0);

    foreach (tbl[v]) begin
      run_op(tbl[v].id, tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].wdata, lat, nre, nwe, scyc, bad);
      chk($sformatf("v%0d_lat", v), lat, tbl[v].exp_lat);
      chk($sformatf("v%0d_re", v), nre, (tbl[v].rd && !tbl[v].wr) ? 1 : 0);
      chk($sformatf("v%0d_we", v), nwe, tbl[v].wr ? 1 : 0);
      chk($sformatf("v%0d_strobe_cyc", v), scyc, 1);
      chk($sformatf("v%0d_port", v), bad, 0);
      chk($sformatf("v%0d_grant", v), grant_id, tbl[v].id);
      chk($sformatf("v%0d_load", v), req_data_load[tbl[v].id*DW +: DW], tbl[v].exp_load);
      chk($sformatf("v%0d_done_drop", v), req_done, 0);
      if (tbl[v].wr) chk($sformatf("v%0d_mem", v), mem[tbl[v].addr[7:0]], tbl[v].wdata);
    end

    // Contention: all four hold reads continuously -> 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b0, 32'h40 + 32'(i), 32'h0);
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      step();
      if (req_done != '0) begin
        did = -1;
        for (int i = 0; i < N; i++) if (req_done[i]) did = i;
        chk($sformatf("cont_onehot%0d", k), $onehot(req_done), 1);
        chk($sformatf("cont_order%0d", k), did, k % N);
        k++;
      end
    end
    chk("cont_complete", k, 8);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    for (int i = 0; i < N; i++)
      chk($sformatf("cont_load%0d", i), req_data_load[i*DW +: DW], 32'hA0000040 + 32'(i));

    // Reset mid-read: abort, then req0 must win over req2.
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    step(); step();
    chk("rmid_busy_before", busy, 1);
    rst = 1'b1; set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); rst = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_strobe", mem_re, 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (req_done != '0 || busy) bad++;
      step();
    end
    chk("rmid_no_done", bad, 0);
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(2, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0);
    for (int i = 0; i < N; i++) exp_ld[i] = 32'hFFFF_FFFF;
    k = 0;
    for (int c = 0; c < 50 && k < 2; c++) begin
      step();
      if (req_done != '0) begin
        did = -1;
        for (int i = 0; i < N; i++) if (req_done[i]) did = i;
        chk($sformatf("rmid_order%0d", k), did, (k == 0) ? 0 : 2);
        if (did == 0) set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        k++;
      end
    end
    chk("rmid_complete", k, 2);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rmid_load0", req_data_load[0*DW +: DW], 32'hDEADBEEF);
    chk("rmid_load2", req_data_load[2*DW +: DW], 32'hA0000012);

    // Both enables: executed as a write, err_both sticky until reset.
    run_op(1, 1'b1, 1'b1, 32'h50, 32'h0000AA55, lat, nre, nwe, scyc, bad);
    chk("both_lat", lat, 2);
    chk("both_re", nre, 0);
    chk("both_we", nwe, 1);
    chk("both_mem", mem[8'h50], 32'h0000AA55);
    chk("both_err", err_both, 1);
    run_op(2, 1'b1, 1'b0, 32'h50, 32'h0, lat, nre, nwe, scyc, bad);
    chk("both_readback", req_data_load[2*DW +: DW], 32'h0000AA55);
    chk("both_err_sticky", err_both, 1);
    do_reset();
    chk("both_err_clr", err_both, 0);

    // Avail without enables on req3 is never granted.
    set_req(3, 1'b1, 1'b0, 1'b0, 32'h60, 32'h0);
    run_op(1, 1'b1, 1'b0, 32'h61, 32'h0, lat, nre, nwe, scyc, bad);
    chk("noen_lat", lat, 4);
    chk("noen_other_done", bad, 0);
    chk("noen_grant", grant_id, 1);
    chk("noen_load", req_data_load[1*DW +: DW], 32'hA0000061);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (busy || req_done != '0) bad++;
    end
    chk("noen_idle", bad, 0);
    set_req(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
